// File: rtl/custom_axi_regif.sv
// AXI4-Lite slave owning NUM_REGS 32-bit shadow registers, bridged to a core's reg2ip/ip2reg port.
// Optional byte-strobe writes are enabled by defining CUSTOM_AXI_REGIF_WSTRB_EN.
module custom_axi_regif #(
  parameter int NUM_REGS = 3,
  parameter int ADDR_W   = 12
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ADDR_W-1:0]       awaddr_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [31:0]             wdata_i,
  input  logic [3:0]              wstrb_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  output logic [1:0]              bresp_o,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  input  logic [ADDR_W-1:0]       araddr_i,
  input  logic                    arvalid_i,
  output logic                    arready_o,
  output logic [31:0]             rdata_o,
  output logic [1:0]              rresp_o,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  output logic [32*NUM_REGS-1:0]  reg2ip_data_o,
  output logic [NUM_REGS-1:0]     reg2ip_en_o,
  input  logic [32*NUM_REGS-1:0]  ip2reg_data_i,
  input  logic [NUM_REGS-1:0]     ip2reg_en_i
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  wstate_e            wstate_q, wstate_d;
  rstate_e            rstate_q, rstate_d;
  logic               aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic               live_q;
  logic [IDX_W-1:0]   waddr_idx_q;
  logic [31:0]        wdata_q;
  logic [1:0]         bresp_q, bresp_d;
  logic [31:0]        rdata_q;
  logic [1:0]         rresp_q;
  logic               aw_hs, w_hs, ar_hs;
  logic [NUM_REGS-1:0] wr_sel;
  logic               wr_hit, rd_hit;
  logic [31:0]        rd_word;
  logic [31:0]        shadow_q [NUM_REGS];
  logic               addr_lsb_unused;

  assign addr_lsb_unused = ^{awaddr_i[1:0], araddr_i[1:0]};

`ifdef CUSTOM_AXI_REGIF_WSTRB_EN
  logic [3:0] wstrb_q;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return res;
  endfunction
`else
  logic wstrb_unused;
  assign wstrb_unused = ^wstrb_i;
`endif

  always_comb begin
    wr_sel = '0;
    rd_hit = 1'b0;
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_sel[i] = (waddr_idx_q == IDX_W'(i));
      if (araddr_i[ADDR_W-1:2] == IDX_W'(i)) begin
        rd_hit  = 1'b1;
        rd_word = shadow_q[i];
      end
    end
    wr_hit = |wr_sel;
  end

  // Write channel: AW and W are held independently until both have arrived.
  always_comb begin
    wstate_d    = wstate_q;
    aw_held_d   = aw_held_q;
    w_held_d    = w_held_q;
    bresp_d     = bresp_q;
    awready_o   = 1'b0;
    wready_o    = 1'b0;
    bvalid_o    = 1'b0;
    reg2ip_en_o = '0;
    aw_hs       = 1'b0;
    w_hs        = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        awready_o = live_q & ~aw_held_q;
        wready_o  = live_q & ~w_held_q;
        aw_hs     = awvalid_i & awready_o;
        w_hs      = wvalid_i & wready_o;
        if (aw_hs) aw_held_d = 1'b1;
        if (w_hs)  w_held_d  = 1'b1;
        if (aw_held_d && w_held_d) wstate_d = W_EXEC;
      end
      W_EXEC: begin
        reg2ip_en_o = wr_sel;
        bresp_d     = wr_hit ? RESP_OKAY : RESP_SLVERR;
        aw_held_d   = 1'b0;
        w_held_d    = 1'b0;
        wstate_d    = W_RESP;
      end
      W_RESP: begin
        bvalid_o = 1'b1;
        if (bready_i) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d  = rstate_q;
    arready_o = live_q & (rstate_q == R_IDLE);
    rvalid_o  = (rstate_q == R_DATA);
    ar_hs     = arvalid_i & arready_o;
    if (ar_hs) rstate_d = R_DATA;
    else if (rvalid_o && rready_i) rstate_d = R_IDLE;
  end

  // live_q keeps all readies low while reset is asserted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      live_q    <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      bresp_q   <= bresp_d;
      live_q    <= 1'b1;
      if (ar_hs) begin
        rdata_q <= rd_hit ? rd_word : '0;
        rresp_q <= rd_hit ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (aw_hs) waddr_idx_q <= awaddr_i[ADDR_W-1:2];
    if (w_hs) begin
      wdata_q <= wdata_i;
`ifdef CUSTOM_AXI_REGIF_WSTRB_EN
      wstrb_q <= wstrb_i;
`endif
    end
  end

  // Bus write wins over a same-cycle core update of the same register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (reg2ip_en_o[i]) begin
`ifdef CUSTOM_AXI_REGIF_WSTRB_EN
          shadow_q[i] <= merge_bytes(shadow_q[i], wdata_q, wstrb_q);
`else
          shadow_q[i] <= wdata_q;
`endif
        end else if (ip2reg_en_i[i]) begin
          shadow_q[i] <= ip2reg_data_i[32*i +: 32];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg2ip_data_o[32*g +: 32] = shadow_q[g];
  end

  assign bresp_o = bresp_q;
  assign rdata_o = rdata_q;
  assign rresp_o = rresp_q;

endmodule

// File: tb/tb_custom_axi_regif.sv
// Directed self-checking bench for custom_axi_regif (NUM_REGS=3, ADDR_W=12).
module tb_custom_axi_regif;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [11:0] awaddr_i = '0;
  logic        awvalid_i = 1'b0;
  logic        awready_o;
  logic [31:0] wdata_i = '0;
  logic [3:0]  wstrb_i = '0;
  logic        wvalid_i = 1'b0;
  logic        wready_o;
  logic [1:0]  bresp_o;
  logic        bvalid_o;
  logic        bready_i = 1'b0;
  logic [11:0] araddr_i = '0;
  logic        arvalid_i = 1'b0;
  logic        arready_o;
  logic [31:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        rvalid_o;
  logic        rready_i = 1'b0;
  logic [95:0] reg2ip_data_o;
  logic [2:0]  reg2ip_en_o;
  logic [95:0] ip2reg_data_i = '0;
  logic [2:0]  ip2reg_en_i = '0;

  custom_axi_regif #(.NUM_REGS(3), .ADDR_W(12)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .reg2ip_data_o(reg2ip_data_o), .reg2ip_en_o(reg2ip_en_o),
    .ip2reg_data_i(ip2reg_data_i), .ip2reg_en_i(ip2reg_en_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0]  w_resp;
  logic [2:0]  w_en_seen;
  int          w_en_cnt, w_en_lat, w_b_lat;
  logic [95:0] w_data_at_en;
  logic [2:0]  coll_mask = '0;
  logic [95:0] coll_data = '0;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  int          r_lat;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int adly, input int wdly, input bit finish_b);
    bit aw_done = 0, w_done = 0, fired = 0, got_b = 0, aw_go, w_go;
    int hs = 0;
    awaddr_i = a; wdata_i = d; wstrb_i = s;
    awvalid_i = (adly == 0);
    wvalid_i  = (wdly == 0);
    w_en_seen = '0; w_en_cnt = 0; w_en_lat = -1; w_b_lat = -1; w_resp = 2'b11;
    for (int c = 0; c < 20 && !got_b; c++) begin
      aw_go = awvalid_i && awready_o;
      w_go  = wvalid_i && wready_o;
      if (aw_go || w_go) hs = c;
      tick();
      ip2reg_en_i = '0;
      if (aw_go) begin awvalid_i = 1'b0; aw_done = 1; end
      if (w_go)  begin wvalid_i = 1'b0;  w_done = 1;  end
      if (!aw_done && c + 1 >= adly) awvalid_i = 1'b1;
      if (!w_done && c + 1 >= wdly)  wvalid_i = 1'b1;
      if (aw_done && w_done && !fired) begin
        ip2reg_en_i = coll_mask; ip2reg_data_i = coll_data; fired = 1;
      end
      if (reg2ip_en_o != '0) begin
        w_en_seen |= reg2ip_en_o; w_en_cnt++; w_en_lat = c + 1 - hs; w_data_at_en = reg2ip_data_o;
      end
      if (bvalid_o) begin got_b = 1; w_b_lat = c + 1 - hs; w_resp = bresp_o; end
    end
    ip2reg_en_i = '0;
    awvalid_i = 1'b0; wvalid_i = 1'b0;
    check("wr_done", got_b, 1);
    if (got_b && finish_b) begin bready_i = 1'b1; tick(); bready_i = 1'b0; end
  endtask

  task automatic do_read(input logic [11:0] a);
    bit got_r = 0, go;
    int hs = 0;
    araddr_i = a; arvalid_i = 1'b1; r_lat = -1; r_data = 'x; r_resp = 'x;
    for (int c = 0; c < 20 && !got_r; c++) begin
      go = arvalid_i && arready_o;
      if (go) hs = c;
      tick();
      if (go) arvalid_i = 1'b0;
      if (rvalid_o) begin got_r = 1; r_lat = c + 1 - hs; r_data = rdata_o; r_resp = rresp_o; end
    end
    arvalid_i = 1'b0;
    check("rd_done", got_r, 1);
    if (got_r) begin rready_i = 1'b1; tick(); rready_i = 1'b0; end
  endtask

  initial begin
    bit hold_ok;
    bit got_r;
    bit ar_go;
    logic [31:0] rd_hold;

    // Reset behaviour
    repeat (2) tick();
    check("rst_awready", awready_o, 0);
    check("rst_wready", wready_o, 0);
    check("rst_arready", arready_o, 0);
    check("rst_valids", {bvalid_o, rvalid_o}, 0);
    rst_ni = 1'b1;
    tick();
    check("post_rst_readies", {awready_o, wready_o, arready_o}, 3'b111);
    check("post_rst_resp", {bresp_o, rresp_o}, 0);
    check("post_rst_rdata", rdata_o, 0);
    check("post_rst_en", reg2ip_en_o, 0);
    check("post_rst_shadow", reg2ip_data_o, 0);

    for (int i = 0; i < 3; i++) begin
      do_read(12'(4 * i));
      check("rd0_data", r_data, 0);
      check("rd0_resp", r_resp, 2'b00);
      check("rd0_lat", r_lat, 1);
    end

    // AW one cycle ahead of W
    do_write(12'h004, 32'hDEAD_BEEF, 4'hF, 0, 1, 1);
    check("w1_en", w_en_seen, 3'b010);
    check("w1_en_cnt", w_en_cnt, 1);
    check("w1_en_lat", w_en_lat, 1);
    check("w1_b_lat", w_b_lat, 2);
    check("w1_old_at_en", w_data_at_en[63:32], 0);
    check("w1_bresp", w_resp, 2'b00);
    check("w1_slice", reg2ip_data_o, {32'h0, 32'hDEAD_BEEF, 32'h0});
    do_read(12'h007);
    check("w1_rd_lsb_ignored", r_data, 32'hDEAD_BEEF);

    // Out-of-range write and read
    do_write(12'h00C, 32'h1234_5678, 4'hF, 1, 0, 1);
    check("oor_bresp", w_resp, 2'b10);
    check("oor_en_cnt", w_en_cnt, 0);
    check("oor_shadow", reg2ip_data_o, {32'h0, 32'hDEAD_BEEF, 32'h0});
    do_read(12'h010);
    check("oor_rresp", r_resp, 2'b10);
    check("oor_rdata", r_data, 0);

    // Byte strobes, AW and W together
    do_write(12'h000, 32'hFFFF_FFFF, 4'hF, 0, 0, 1);
    do_write(12'h000, 32'h1122_3344, 4'b0011, 0, 0, 1);
`ifdef CUSTOM_AXI_REGIF_WSTRB_EN
    check("wstrb_shadow0", reg2ip_data_o[31:0], 32'hFFFF_3344);
`else
    check("wstrb_shadow0", reg2ip_data_o[31:0], 32'h1122_3344);
`endif
    check("wstrb_en", w_en_seen, 3'b001);

    // Core update colliding with a bus write to reg2; reg0 takes its core update
    coll_mask = 3'b101;
    coll_data = {32'hA5A5_A5A5, 32'h0, 32'h0BAD_F00D};
    do_write(12'h008, 32'h0000_0001, 4'hF, 0, 0, 1);
    coll_mask = '0;
    check("coll_reg2", reg2ip_data_o[95:64], 32'h1);
    check("coll_reg0", reg2ip_data_o[31:0], 32'h0BAD_F00D);
    ip2reg_data_i = {32'hA5A5_A5A5, 32'h0, 32'h0};
    ip2reg_en_i = 3'b100;
    tick();
    ip2reg_en_i = '0;
    do_read(12'h008);
    check("core_upd_rd", r_data, 32'hA5A5_A5A5);

    // B stalled for 5 cycles with a concurrent read, then reset mid-wait
    do_write(12'h004, 32'h0000_0055, 4'hF, 0, 0, 0);
    hold_ok = 1; got_r = 0; rd_hold = '0;
    araddr_i = 12'h004; arvalid_i = 1'b1; rready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      hold_ok &= bvalid_o & ~awready_o;
      ar_go = arvalid_i && arready_o;
      if (rvalid_o && !got_r) begin got_r = 1; rd_hold = rdata_o; end
      tick();
      if (ar_go) arvalid_i = 1'b0;
    end
    rready_i = 1'b0; arvalid_i = 1'b0;
    check("bhold_stable", {hold_ok, bvalid_o}, 2'b11);
    check("bhold_rd_done", got_r, 1);
    check("bhold_rd_data", rd_hold, 32'h55);
    rst_ni = 1'b0;
    #1;
    check("rst_mid_bvalid", bvalid_o, 0);
    tick();
    rst_ni = 1'b1;
    tick();
    check("rst_mid_idle", {bvalid_o, awready_o, wready_o}, 3'b011);
    check("rst_mid_shadow", reg2ip_data_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/custom_axi_regif.md
# custom_axi_regif

AXI4-Lite slave front end that owns a bank of 32-bit shadow registers and drives the reg2ip/ip2reg port of a custom peripheral core. It sits directly upstream of the core. It converts bus writes into one-cycle `reg2ip_en_o` strobes carrying the written word. It returns shadow contents on bus reads, and the shadow is refreshed by the core through `ip2reg_en_i`/`ip2reg_data_i`.

## Interface
Parameters:
- `NUM_REGS`, 3: number of 32-bit registers (1..16).
- `ADDR_W`, 12: AXI address width; register index = `addr[ADDR_W-1:2]`.

Ports:
- `clk_i`  in  1  clock, all logic on rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `awaddr_i`  in  ADDR_W  write address.
- `awvalid_i` / `awready_o`  in/out  1  AW handshake.
- `wdata_i`  in  32  write data.
- `wstrb_i`  in  4  byte strobes.
- `wvalid_i` / `wready_o`  in/out  1  W handshake.
- `bresp_o`  out  2  write response.
- `bvalid_o` / `bready_i`  out/in  1  B handshake.
- `araddr_i`  in  ADDR_W  read address.
- `arvalid_i` / `arready_o`  in/out  1  AR handshake.
- `rdata_o`  out  32  read data.
- `rresp_o`  out  2  read response.
- `rvalid_o` / `rready_i`  out/in  1  R handshake.
- `reg2ip_data_o`  out  32*NUM_REGS  shadow contents; reg i in bits [32i+31:32i].
- `reg2ip_en_o`  out  NUM_REGS  one-cycle write strobe per register.
- `ip2reg_data_i`  in  32*NUM_REGS  core update values.
- `ip2reg_en_i`  in  NUM_REGS  core update enables.

## Operation
- The shadow registers reset to 0. `reg2ip_data_o` is the shadow, driven continuously.
- Write FSM states:
  - W_IDLE: `awready_o` = !aw_held, `wready_o` = !w_held. AW and W are captured independently, in either order or the same cycle. When both are held, go to W_EXEC.
  - W_EXEC (one cycle): decode the index.
    - In range: update the shadow, pulse `reg2ip_en_o[idx]`, set bresp = OKAY (2'b00).
    - Out of range: no update, no strobe, bresp = SLVERR (2'b10).
    - Clear both held flags and go to W_RESP.
  - W_RESP: `bvalid_o` = 1 until `bready_i`, then go to W_IDLE.
- Read FSM states:
  - R_IDLE: `arready_o` = 1. On handshake, register `rdata_o` from the shadow, or 0 with SLVERR when out of range, and go to R_DATA.
  - R_DATA: `rvalid_o` = 1. `rdata_o`/`rresp_o` stay stable until `rready_i`, then go to R_IDLE.
- Core update: `ip2reg_en_i[i]` = 1 loads `shadow[i]` from its slice on the next edge.
- Collision: a W_EXEC bus write to reg i in the same cycle as `ip2reg_en_i[i]` resolves to the bus value. Other registers still take their core updates.
- A read and a write proceed concurrently. A read that handshakes in the W_EXEC cycle returns the pre-write value.
- Address bits [1:0] are ignored. Only one outstanding transaction per channel.

## Timing
- Reset values: all ready/valid outputs 0 during reset. In the first cycle after reset, `awready_o` = `wready_o` = `arready_o` = 1. `bresp_o` = `rresp_o` = 0, `rdata_o` = 0, `reg2ip_en_o` = 0, shadow = 0.
- Write: the last of AW/W handshakes in cycle T. W_EXEC and the strobe occur in T+1. The new `reg2ip_data_o` is visible from T+2. `bvalid_o` rises in T+2.
- Read: AR handshake in T, `rvalid_o` rises in T+1. Sustained throughput is one read every 2 cycles and one write every 3 cycles.
- Asserting reset mid-transaction aborts it. FSMs return to idle and no pending B/R is issued.

## Configuration
- Macro `CUSTOM_AXI_REGIF_WSTRB_EN`.
- Defined: only the bytes with `wstrb_i[b]` = 1 are written. The strobe still pulses even when `wstrb_i` = 0.
- Undefined: `wstrb_i` is ignored and the full 32-bit word is written.

## Test plan
- Reset, then read reg0..2 -> each returns 0x0000_0000 with OKAY and `rvalid_o` at T+1.
- Write 0xDEAD_BEEF to 0x004 with AW one cycle before W:
  - `reg2ip_en_o` = 3'b010 for exactly one cycle.
  - Slice 1 = 0xDEAD_BEEF.
  - bresp OKAY.
- Write to 0x00C, then read 0x010 -> both return SLVERR. No strobe, shadow unchanged, rdata 0.
- With the macro defined: write 0x1122_3344 with wstrb 4'b0011 over 0xFFFF_FFFF -> shadow = 0xFFFF_3344. With the macro undefined -> 0x1122_3344.
- `ip2reg_en_i[2]` with 0xA5A5_A5A5 in the same cycle as a W_EXEC write of 0x1 to reg2 -> shadow2 = 0x1. A later core update makes a read return 0xA5A5_A5A5.
- Hold `bready_i` = 0 for 5 cycles:
  - `bvalid_o` stays 1 and `awready_o` stays 0.
  - A concurrent read still completes.
  - Asserting reset mid-wait clears `bvalid_o`.
